program_sequencer: RTL

- Parametrised multi-core run controller for the program test harness.
- Per run:
  - selects one of NUM_PROGS program cores, either by round-robin rotation or by explicit select;
  - preloads that core's data RAM from the shared image memory, using a per-program region table;
  - releases the core's init and waits for its done, with a timeout guard;
  - reports a single done/timeout status to the testbench.

---
 rtl/program_seq_pkg.sv | 28 ++
 rtl/region_walker.sv | 91 +++++++++
 rtl/program_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/program_seq_pkg.sv
// rtl/program_seq_pkg.sv - shared types, states and preload region table for program_sequencer
package program_seq_pkg;

    localparam int PKG_NUM_PROGS   = 3;
    localparam int PKG_MAX_REGIONS = 2;
    localparam int PKG_ADDR_W      = 8;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] base;
        logic [PKG_ADDR_W-1:0] len;
    } region_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } state_e;

    // A region with len == 0 is unused and skipped by the walker.
    localparam region_t REGION_TABLE [PKG_NUM_PROGS][PKG_MAX_REGIONS] = '{
        '{'{base: 8'd1,   len: 8'd3},  '{base: 8'd0,  len: 8'd0}},
        '{'{base: 8'd6,   len: 8'd1},  '{base: 8'd32, len: 8'd64}},
        '{'{base: 8'd128, len: 8'd20}, '{base: 8'd0,  len: 8'd0}}
    };

endpackage

// File: rtl/region_walker.sv
// rtl/region_walker.sv - streams image addresses over a program's active regions with a one-cycle write pipe
module region_walker
    import program_seq_pkg::*;
#(
    parameter int MAX_REGIONS = PKG_MAX_REGIONS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             go_i,
    input  region_t [MAX_REGIONS-1:0]        regions_i,
    output logic    [PKG_ADDR_W-1:0]         img_addr_o,
    output logic    [PKG_ADDR_W-1:0]         wr_addr_o,
    output logic                             wr_valid_o,
    output logic                             last_o
);

    localparam int RW = (MAX_REGIONS > 1) ? $clog2(MAX_REGIONS) : 1;
    localparam int AW = PKG_ADDR_W;

    logic          issuing_q;
    logic          empty_q;
    logic [RW-1:0] ridx_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rem_q;
    logic          wr_valid_q;
    logic [AW-1:0] wr_addr_q;

    logic          first_ok;
    logic [RW-1:0] first_idx;
    logic          next_ok;
    logic [RW-1:0] next_idx;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        for (int r = MAX_REGIONS - 1; r >= 0; r--) begin
            if (regions_i[r].len != '0) begin
                first_ok  = 1'b1;
                first_idx = RW'(r);
                if (r > int'(ridx_q)) begin
                    next_ok  = 1'b1;
                    next_idx = RW'(r);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issuing_q  <= 1'b0;
            empty_q    <= 1'b0;
            ridx_q     <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_valid_q <= issuing_q;
            if (issuing_q) begin
                wr_addr_q <= addr_q;
            end
            empty_q <= go_i && !first_ok;
            if (go_i) begin
                issuing_q <= first_ok;
                ridx_q    <= first_idx;
                addr_q    <= regions_i[first_idx].base;
                rem_q     <= regions_i[first_idx].len;
            end else if (issuing_q) begin
                if (rem_q != AW'(1)) begin
                    addr_q <= addr_q + AW'(1);
                    rem_q  <= rem_q - AW'(1);
                end else if (next_ok) begin
                    ridx_q <= next_idx;
                    addr_q <= regions_i[next_idx].base;
                    rem_q  <= regions_i[next_idx].len;
                end else begin
                    issuing_q <= 1'b0;
                end
            end
        end
    end

    assign img_addr_o = addr_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_valid_o = wr_valid_q;
    assign last_o     = empty_q | (issuing_q & (rem_q == AW'(1)) & ~next_ok);

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - multi-core run controller: select, preload, release, run with timeout
module program_sequencer
    import program_seq_pkg::*;
#(
    parameter int NUM_PROGS      = PKG_NUM_PROGS,
    parameter int ADDR_W         = PKG_ADDR_W,
    parameter int DATA_W         = 8,
    parameter int MAX_REGIONS    = PKG_MAX_REGIONS,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int PW            = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 auto_rotate,
    input  logic [PW-1:0]        prog_sel,
    output logic [ADDR_W-1:0]    img_addr,
    input  logic [DATA_W-1:0]    img_rdata,
    output logic [NUM_PROGS-1:0] core_we,
    output logic [ADDR_W-1:0]    core_waddr,
    output logic [DATA_W-1:0]    core_wdata,
    output logic [NUM_PROGS-1:0] core_init,
    input  logic [NUM_PROGS-1:0] core_done,
    output logic [PW-1:0]        active_prog,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [PW-1:0]          rot_q, rot_d;
    logic [PW-1:0]          active_q, active_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_PROGS-1:0]   init_q, init_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   go;
    logic [PW-1:0]          sel_p;
    logic [PW-1:0]          walk_prog;
    region_t [MAX_REGIONS-1:0] walk_regions;
    logic                   walk_valid;
    logic                   walk_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rot_q     <= PW'(NUM_PROGS - 1);
            active_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            init_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rot_q     <= rot_d;
            active_q  <= active_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            init_q    <= init_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rot_d     = rot_q;
        active_d  = active_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        init_d    = init_q;
        cnt_d     = cnt_q;
        go        = 1'b0;
        if (auto_rotate) begin
            sel_p = (rot_q == PW'(NUM_PROGS - 1)) ? '0 : rot_q + PW'(1);
        end else begin
            sel_p = (prog_sel > PW'(NUM_PROGS - 1)) ? PW'(NUM_PROGS - 1) : prog_sel;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    go        = 1'b1;
                    active_d  = sel_p;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    init_d    = NUM_PROGS'(1) << sel_p;
                    state_d   = LOAD;
                    if (auto_rotate) begin
                        rot_d = sel_p;
                    end
                end
            end
            LOAD: begin
                if (walk_last) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                init_d  = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                // A done seen in the final timeout cycle still counts as success.
                if (core_done[active_q]) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The walker must see the new program's regions in the accept cycle itself.
    assign walk_prog = go ? sel_p : active_q;

    always_comb begin
        walk_regions = '0;
        for (int r = 0; r < MAX_REGIONS; r++) begin
            walk_regions[r] = REGION_TABLE[walk_prog][r];
        end
    end

    region_walker #(
        .MAX_REGIONS(MAX_REGIONS)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .go_i       (go),
        .regions_i  (walk_regions),
        .img_addr_o (img_addr),
        .wr_addr_o  (core_waddr),
        .wr_valid_o (walk_valid),
        .last_o     (walk_last)
    );

    assign core_we     = walk_valid ? (NUM_PROGS'(1) << active_q) : '0;
    assign core_wdata  = walk_valid ? img_rdata : '0;
    assign core_init   = init_q;
    assign active_prog = active_q;
    assign busy        = (state_q == LOAD) || (state_q == RELEASE) || (state_q == RUN);
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule
